turn_ctrl: RTL and testbench

TURN_CTRL -- requirements
Module: turn_ctrl

---
 rtl/turn_ctrl.sv | 150 +++++++++++++++
 tb/tb_turn_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_ctrl.sv
// turn_ctrl -- turn sequencer for a multi-player stone-placing board game.
//
// Walks each turn through choice, button release, stone write, win/draw
// check and player hand-over. Ends the game on a win or a full board and
// restarts on new_game.
//
// Optional feature: define TURN_CTRL_TIMEOUT_EN to add a per-turn timer.
// The timer forces a skip to the next player after TURN_TIMEOUT idle cycles
// in CHOICE.
//
// Ports:
//   clock        rising-edge system clock
//   resetn       asynchronous active-low reset
//   put          synchronised put-button level
//   legal        cursor cell is empty (sampled when put is pressed in CHOICE)
//   check_done   win/draw checker result valid
//   win          current player has five in a row (qualified by check_done)
//   board_full   no empty cell left (qualified by check_done)
//   new_game     single-cycle restart request, highest priority
//   player       index of the player whose turn it is
//   cursor_en    cursor may move (CHOICE)
//   write_en     one-cycle stone commit strobe (WRITE)
//   check_req    held high while waiting for the checker (CHECK)
//   change_turn  one-cycle player-advance strobe (CHANGE)
//   control_set  one-cycle cursor reset strobe (CHANGE)
//   timeout      one-cycle strobe accompanying a forced skip
//   game_over    high while the game is finished
//   winner       {valid, index}; all-zero means draw or no result
module turn_ctrl #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned PW           = 3,
  parameter int unsigned TURN_TIMEOUT = 1000
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          put,
  input  logic          legal,
  input  logic          check_done,
  input  logic          win,
  input  logic          board_full,
  input  logic          new_game,
  output logic [PW-1:0] player,
  output logic          cursor_en,
  output logic          write_en,
  output logic          check_req,
  output logic          change_turn,
  output logic          control_set,
  output logic          timeout,
  output logic          game_over,
  output logic [PW:0]   winner
);

  typedef enum logic [2:0] {
    S_INITIAL   = 3'd0,
    S_CHOICE    = 3'd1,
    S_PUT_WAIT  = 3'd2,
    S_WRITE     = 3'd3,
    S_CHECK     = 3'd4,
    S_CHANGE    = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_t state, state_nxt;
  logic   legal_q;
  logic   expire;

`ifdef TURN_CTRL_TIMEOUT_EN
  localparam int unsigned   TW     = $clog2(TURN_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TURN_TIMEOUT - 1);

  logic [TW-1:0] turn_cnt;
  logic          skip_q;

  // Held at zero outside CHOICE, so every entry to CHOICE starts from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                turn_cnt <= '0;
    else if (state != S_CHOICE) turn_cnt <= '0;
    else                        turn_cnt <= turn_cnt + 1'b1;
  end

  assign expire = (state == S_CHOICE) && (turn_cnt == T_LAST);

  // Remembers that CHANGE was reached by a forced skip, so timeout is
  // decoded from registered state together with change_turn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) skip_q <= 1'b0;
    else         skip_q <= expire && !put && !new_game;
  end

  assign timeout = (state == S_CHANGE) && skip_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_INITIAL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_INITIAL;
    end else begin
      unique case (state)
        S_INITIAL:   state_nxt = S_CHOICE;
        S_CHOICE:    if (put)         state_nxt = S_PUT_WAIT;
                     else if (expire) state_nxt = S_CHANGE;
        S_PUT_WAIT:  if (!put)        state_nxt = legal_q ? S_WRITE : S_CHOICE;
        S_WRITE:     state_nxt = S_CHECK;
        S_CHECK:     if (check_done)
                       state_nxt = (win || board_full) ? S_GAME_OVER : S_CHANGE;
        S_CHANGE:    state_nxt = S_CHOICE;
        S_GAME_OVER: state_nxt = S_GAME_OVER;
        default:     state_nxt = S_INITIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      player  <= '0;
      winner  <= '0;
      legal_q <= 1'b0;
    end else if (new_game) begin
      player  <= '0;
      winner  <= '0;
      legal_q <= 1'b0;
    end else begin
      if (state == S_CHOICE && put) legal_q <= legal;
      // Player updates on the edge leaving CHANGE; the new index is seen in CHOICE.
      if (state == S_CHANGE)
        player <= (player == LAST_PLAYER) ? '0 : player + 1'b1;
      // win outranks board_full when both are reported together.
      if (state == S_CHECK && check_done)
        winner <= win ? {1'b1, player} : '0;
    end
  end

  assign cursor_en   = (state == S_CHOICE);
  assign write_en    = (state == S_WRITE);
  assign check_req   = (state == S_CHECK);
  assign change_turn = (state == S_CHANGE);
  assign control_set = (state == S_CHANGE);
  assign game_over   = (state == S_GAME_OVER);

endmodule

// File: tb/tb_turn_ctrl.sv
module tb_turn_ctrl;

  localparam int NP = 3;
  localparam int PW = 2;
  localparam int TT = 8;

  // Expected output patterns: {cursor_en, write_en, check_req, change_turn,
  // control_set, timeout, game_over}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_CHOICE = 7'b1000000;
  localparam logic [6:0] O_WRITE  = 7'b0100000;
  localparam logic [6:0] O_CHECK  = 7'b0010000;
  localparam logic [6:0] O_CHANGE = 7'b0001100;
  localparam logic [6:0] O_SKIP   = 7'b0001110;
  localparam logic [6:0] O_GO     = 7'b0000001;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic put = 1'b0, legal = 1'b0, check_done = 1'b0;
  logic win = 1'b0, board_full = 1'b0, new_game = 1'b0;
  logic [PW-1:0] player;
  logic [PW:0]   winner;
  logic cursor_en, write_en, check_req, change_turn, control_set, timeout, game_over;

  int total = 0;
  int bad   = 0;
  int exp_player = 0;
  int exp_winner = 0;

  turn_ctrl #(.NUM_PLAYERS(NP), .PW(PW), .TURN_TIMEOUT(TT)) dut (
    .clock(clock), .resetn(resetn), .put(put), .legal(legal),
    .check_done(check_done), .win(win), .board_full(board_full),
    .new_game(new_game), .player(player), .cursor_en(cursor_en),
    .write_en(write_en), .check_req(check_req), .change_turn(change_turn),
    .control_set(control_set), .timeout(timeout), .game_over(game_over),
    .winner(winner)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs_now();
    return {cursor_en, write_en, check_req, change_turn, control_set, timeout, game_over};
  endfunction

  task automatic exp_cycle(input string tag, input logic [6:0] o);
    chk({tag, ".outs"},   32'(outs_now()), 32'(o));
    chk({tag, ".player"}, 32'(player), exp_player);
    chk({tag, ".winner"}, 32'(winner), exp_winner);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One turn starting in the first cycle of CHOICE: idle cycles, press for
  // hold cycles, release, then (if legal) write and check with a checker delay.
  task automatic do_turn(input bit lg, input int idle, input int hold,
                         input int dly, input bit w, input bit full);
    for (int i = 0; i < idle; i++) begin
      put = 1'b0; legal = 1'($urandom);
      step(); exp_cycle("idle", O_CHOICE);
    end
    put = 1'b1; legal = lg;
    step(); legal = 1'($urandom);
    exp_cycle("put_wait", O_NONE);
    for (int i = 1; i < hold; i++) begin
      step(); legal = 1'($urandom);
      exp_cycle("put_hold", O_NONE);
    end
    put = 1'b0;
    step();
    if (!lg) begin
      exp_cycle("reject", O_CHOICE);
      return;
    end
    exp_cycle("write", O_WRITE);
    check_done = 1'b0; win = 1'($urandom); board_full = 1'($urandom);
    step(); exp_cycle("check", O_CHECK);
    for (int i = 0; i < dly; i++) begin
      win = 1'($urandom); board_full = 1'($urandom);
      step(); exp_cycle("check_wait", O_CHECK);
    end
    check_done = 1'b1; win = w; board_full = full;
    step();
    check_done = 1'b0; win = 1'b0; board_full = 1'b0;
    if (w) begin
      exp_winner = (1 << PW) | exp_player;
      exp_cycle("win", O_GO);
    end else if (full) begin
      exp_winner = 0;
      exp_cycle("draw", O_GO);
    end else begin
      exp_cycle("change", O_CHANGE);
      exp_player = (exp_player + 1) % NP;
      step(); exp_cycle("next", O_CHOICE);
    end
  endtask

  task automatic hold_game_over(input int n);
    for (int i = 0; i < n; i++) begin
      put = 1'($urandom); legal = 1'($urandom);
      check_done = 1'($urandom); win = 1'($urandom); board_full = 1'($urandom);
      step(); exp_cycle("hold_go", O_GO);
    end
    put = 1'b0; check_done = 1'b0; win = 1'b0; board_full = 1'b0;
  endtask

  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    exp_player = 0; exp_winner = 0;
    exp_cycle("restart", O_NONE);
    step(); exp_cycle("restart_choice", O_CHOICE);
  endtask

  initial begin
    // Asynchronous reset state
    #1 exp_cycle("reset", O_NONE);
    #11 resetn = 1'b1;
    step(); exp_cycle("first_choice", O_CHOICE);

    // Basic legal turn, long press
    do_turn(1'b1, 0, 3, 0, 1'b0, 1'b0);
    // Illegal press: no turn change
    do_turn(1'b0, 1, 2, 0, 1'b0, 1'b0);
    // Player 1 wins with board_full also high
    do_turn(1'b1, 0, 1, 1, 1'b1, 1'b1);
    hold_game_over(4);
    restart();

    // Three-player rotation 0,1,2,0
    for (int t = 0; t < 3; t++) do_turn(1'b1, 1, 1, 0, 1'b0, 1'b0);
    chk("rotation_wrap", 32'(player), 0);

`ifdef TURN_CTRL_TIMEOUT_EN
    for (int i = 1; i < TT; i++) begin
      step(); exp_cycle("to_idle", O_CHOICE);
    end
    step(); exp_cycle("to_skip", O_SKIP);
    exp_player = (exp_player + 1) % NP;
    step(); exp_cycle("to_after", O_CHOICE);
    // Press lands exactly on the expiring cycle: put wins
    do_turn(1'b1, TT - 1, 1, 0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 3 * TT; i++) begin
      step(); exp_cycle("no_timer_idle", O_CHOICE);
    end
`endif

    // new_game during PUT_WAIT, then together with a press in CHOICE
    do_turn(1'b1, 0, 1, 0, 1'b0, 1'b0);
    put = 1'b1; legal = 1'b1;
    step(); exp_cycle("ng_put_wait", O_NONE);
    restart();
    put = 1'b1; new_game = 1'b1;
    step();
    put = 1'b0; new_game = 1'b0;
    exp_player = 0; exp_winner = 0;
    exp_cycle("ng_over_put", O_NONE);
    step(); exp_cycle("ng_over_put_choice", O_CHOICE);

    // Asynchronous reset while in CHECK with a nonzero player
    do_turn(1'b1, 0, 1, 0, 1'b0, 1'b0);
    put = 1'b1; legal = 1'b1;
    step(); put = 1'b0;
    step(); exp_cycle("pre_rst_write", O_WRITE);
    step(); exp_cycle("pre_rst_check", O_CHECK);
    #2 resetn = 1'b0;
    #1 exp_player = 0; exp_winner = 0;
    exp_cycle("async_rst", O_NONE);
    step(); exp_cycle("rst_hold", O_NONE);
    @(negedge clock) resetn = 1'b1;
    step(); exp_cycle("rst_choice", O_CHOICE);

    // Randomized turns
    for (int t = 0; t < 60; t++) begin
      bit lg, w, full;
      lg   = ($urandom_range(9) < 7);
      w    = ($urandom_range(9) == 0);
      full = ($urandom_range(9) == 0);
      do_turn(lg, $urandom_range(5), $urandom_range(1, 4),
              $urandom_range(3), w, full);
      if (lg && (w || full)) begin
        hold_game_over($urandom_range(1, 4));
        restart();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
